// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronise and filter the pins, deframe 11-bit frames,
// fold E0/F0 prefixes into flags and queue key events in a small FIFO.
module ps2_keyboard_rx #(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned FILTER     = 4,
   parameter int unsigned TIMEOUT    = 100_000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] key_code,
   output logic       key_brk,
   output logic       key_ext,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       err_parity,
   output logic       err_frame,
   output logic       overflow
);

   localparam int unsigned FW = $clog2(FILTER + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   if (CLK_HZ == 0 || FILTER == 0 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("ps2_keyboard_rx: illegal parameter value");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

   logic [1:0]    csync_q, csync_d, dsync_q, dsync_d;
   logic          cfilt_q, cfilt_d, cprev_q, cprev_d, fe_q, fe_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   state_t        state_q, state_d;
   logic [2:0]    bcnt_q, bcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d, stop_q, stop_d, done_q, done_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          ext_q, ext_d, brk_q, brk_d;
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [9:0]    mem_q [FIFO_DEPTH];
   logic [9:0]    head;
   logic          dat, tmo_hit, par_bad, frame_bad, good, push, pop, wr_en, full;

   // Filtered clock only changes once FILTER consecutive samples disagree with it.
   always_comb begin
      csync_d = {csync_q[0], ps2_clk};
      dsync_d = {dsync_q[0], ps2_dat};
      cfilt_d = cfilt_q;
      fcnt_d  = '0;
      if (csync_q[1] != cfilt_q) begin
         if (fcnt_q == FW'(FILTER - 1)) cfilt_d = csync_q[1];
         else                           fcnt_d  = fcnt_q + 1'b1;
      end
      cprev_d = cfilt_q;
      fe_d    = cprev_q & ~cfilt_q;
   end

   assign dat = dsync_q[1];

   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      shift_d = shift_q;
      par_d   = par_q;
      stop_d  = stop_q;
      done_d  = 1'b0;
      tmo_hit = 1'b0;
      if (fe_q) begin
         case (state_q)
            ST_IDLE: if (!dat) begin
               state_d = ST_DATA;
               bcnt_d  = '0;
            end
            ST_DATA: begin
               shift_d = {dat, shift_q[7:1]};
               bcnt_d  = bcnt_q + 1'b1;
               if (bcnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               par_d   = dat;
               state_d = ST_STOP;
            end
            default: begin
               stop_d  = dat;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         endcase
      end else if (state_q != ST_IDLE && tmo_q == TW'(TIMEOUT)) begin
         tmo_hit = 1'b1;
         state_d = ST_IDLE;
      end
      // Counter value equals cycles elapsed since the most recent fe.
      if (state_d == ST_IDLE) tmo_d = '0;
      else if (fe_q)          tmo_d = TW'(1);
      else                    tmo_d = tmo_q + 1'b1;
   end

   always_comb begin
      frame_bad  = done_q & ~stop_q;
      par_bad    = done_q & stop_q & ~(^{shift_q, par_q});
      good       = done_q & stop_q & (^{shift_q, par_q});
      push       = good && shift_q != 8'hE0 && shift_q != 8'hF0;
      err_parity = par_bad;
      err_frame  = frame_bad | tmo_hit;
      ext_d      = ext_q;
      brk_d      = brk_q;
      if (frame_bad || par_bad || tmo_hit || push) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (good && shift_q == 8'hE0) begin
         ext_d = 1'b1;
      end else if (good) begin
         brk_d = 1'b1;
      end
   end

   always_comb begin
      key_valid = cnt_q != '0;
      full      = cnt_q == CW'(FIFO_DEPTH);
      pop       = key_valid & key_ready;
      wr_en     = push & (~full | pop);
      overflow  = push & full & ~pop;
      rd_d      = rd_q + PW'(pop);
      wr_d      = wr_q + PW'(wr_en);
      cnt_d     = cnt_q + CW'(wr_en) - CW'(pop);
      head      = mem_q[rd_q];
      key_code  = key_valid ? head[7:0] : '0;
      key_brk   = key_valid & head[8];
      key_ext   = key_valid & head[9];
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q] <= {ext_q, brk_q, shift_q};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csync_q <= '1;
         dsync_q <= '1;
         cfilt_q <= 1'b1;
         cprev_q <= 1'b1;
         fe_q    <= 1'b0;
         fcnt_q  <= '0;
         state_q <= ST_IDLE;
         bcnt_q  <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         stop_q  <= 1'b0;
         done_q  <= 1'b0;
         tmo_q   <= '0;
         ext_q   <= 1'b0;
         brk_q   <= 1'b0;
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         csync_q <= csync_d;
         dsync_q <= dsync_d;
         cfilt_q <= cfilt_d;
         cprev_q <= cprev_d;
         fe_q    <= fe_d;
         fcnt_q  <= fcnt_d;
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         stop_q  <= stop_d;
         done_q  <= done_d;
         tmo_q   <= tmo_d;
         ext_q   <= ext_d;
         brk_q   <= brk_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
